// File: rtl/sseg_scan_arbiter_if.sv
// Bundle of requester-side signals for the two-owner multiplexed 7-segment scanner.
// The master modport is the requester/bench side; the slave modport is the scanner itself.
`timescale 1ns/1ps
interface sseg_scan_arbiter_if;
    logic        req_a;
    logic        req_b;
    logic [23:0] data_a;
    logic [23:0] data_b;
    logic [5:0]  dp_a;
    logic [5:0]  dp_b;
    logic        gnt_a;
    logic        gnt_b;
    logic        frame_done;
    logic [7:0]  sseg;
    logic [5:0]  en;

    modport master (
        output req_a, req_b, data_a, data_b, dp_a, dp_b,
        input  gnt_a, gnt_b, frame_done, sseg, en
    );

    modport slave (
        input  req_a, req_b, data_a, data_b, dp_a, dp_b,
        output gnt_a, gnt_b, frame_done, sseg, en
    );
endinterface

// File: rtl/sseg_scan_arbiter.sv
// Six-digit multiplexed 7-segment scanner shared by two requesters.
// Ownership and the displayed digits only change at frame boundaries, so a frame never tears.
`timescale 1ns/1ps
module sseg_scan_arbiter #(
    parameter int CLK_DIV     = 25000,
    parameter int BLANK       = 2,
    parameter int HOLD_FRAMES = 8
) (
    input logic               clk,
    input logic               rst,
    sseg_scan_arbiter_if.slave bus
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HW = $clog2(HOLD_FRAMES + 1);

    localparam logic [CW-1:0] COUNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_END  = CW'(BLANK);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_FRAMES - 1);
    localparam logic [2:0]    IDX_LAST   = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    logic [CW-1:0] count_reg;
    logic [2:0]    idx_reg;
    logic          frame_done_reg;
    logic          slot_tick;
    logic          frame_edge;

    state_t        state_reg;
    state_t        state_next;
    logic          gnt_a_reg;
    logic          gnt_b_reg;
    logic          last_b_reg;
    logic [HW-1:0] hold_reg;
    logic [23:0]   shadow_data_reg;
    logic [5:0]    shadow_dp_reg;

    logic [3:0]    digit_code [6];
    logic [5:0]    en_active;
    logic [3:0]    code_sel;
    logic          dp_sel;
    logic [7:0]    seg_code;
    logic          blank;
    logic [7:0]    sseg_reg;
    logic [5:0]    en_reg;

    assign slot_tick  = (count_reg == COUNT_LAST);
    assign frame_edge = slot_tick && (idx_reg == IDX_LAST);

    // Slot prescaler and digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            idx_reg   <= '0;
        end else if (slot_tick) begin
            count_reg <= '0;
            idx_reg   <= (idx_reg == IDX_LAST) ? 3'd0 : idx_reg + 3'd1;
        end else begin
            count_reg <= count_reg + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= frame_edge;
        end
    end

    // Ownership decision, evaluated only where the register block consumes it
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.req_a && bus.req_b) begin
                    state_next = last_b_reg ? OWN_A : OWN_B;
                end else if (bus.req_a) begin
                    state_next = OWN_A;
                end else if (bus.req_b) begin
                    state_next = OWN_B;
                end
            end
            OWN_A: begin
                if (!bus.req_a) begin
                    state_next = bus.req_b ? OWN_B : IDLE;
                end else if (bus.req_b && (hold_reg >= HOLD_LAST)) begin
                    state_next = OWN_B;
                end
            end
            OWN_B: begin
                if (!bus.req_b) begin
                    state_next = bus.req_a ? OWN_A : IDLE;
                end else if (bus.req_a && (hold_reg >= HOLD_LAST)) begin
                    state_next = OWN_A;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Arbiter state, grants, hold counter and shadow copy all move together at the boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            gnt_a_reg       <= 1'b0;
            gnt_b_reg       <= 1'b0;
            last_b_reg      <= 1'b1;
            hold_reg        <= '0;
            shadow_data_reg <= '0;
            shadow_dp_reg   <= '0;
        end else if (frame_edge) begin
            state_reg <= state_next;
            gnt_a_reg <= (state_next == OWN_A);
            gnt_b_reg <= (state_next == OWN_B);

            if (state_next != state_reg) begin
                hold_reg <= '0;
            end else if ((state_reg != IDLE) && (hold_reg != HOLD_LAST)) begin
                hold_reg <= hold_reg + HW'(1);
            end

            case (state_next)
                OWN_A: begin
                    shadow_data_reg <= bus.data_a;
                    shadow_dp_reg   <= bus.dp_a;
                    last_b_reg      <= 1'b0;
                end
                OWN_B: begin
                    shadow_data_reg <= bus.data_b;
                    shadow_dp_reg   <= bus.dp_b;
                    last_b_reg      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    for (genvar gi = 0; gi < 6; gi++) begin : g_digit
        assign digit_code[gi] = shadow_data_reg[4*gi +: 4];
        assign en_active[gi]  = (idx_reg != 3'(gi));
    end

    always_comb begin
        code_sel = 4'd0;
        dp_sel   = 1'b0;
        case (idx_reg)
            3'd0: begin code_sel = digit_code[0]; dp_sel = shadow_dp_reg[0]; end
            3'd1: begin code_sel = digit_code[1]; dp_sel = shadow_dp_reg[1]; end
            3'd2: begin code_sel = digit_code[2]; dp_sel = shadow_dp_reg[2]; end
            3'd3: begin code_sel = digit_code[3]; dp_sel = shadow_dp_reg[3]; end
            3'd4: begin code_sel = digit_code[4]; dp_sel = shadow_dp_reg[4]; end
            3'd5: begin code_sel = digit_code[5]; dp_sel = shadow_dp_reg[5]; end
            default: ;
        endcase
    end

    always_comb begin
        seg_code = 8'hFF;
        case (code_sel)
            4'd0: seg_code = 8'hC0;
            4'd1: seg_code = 8'hF9;
            4'd2: seg_code = 8'hA4;
            4'd3: seg_code = 8'hB0;
            4'd4: seg_code = 8'h99;
            4'd5: seg_code = 8'h92;
            4'd6: seg_code = 8'h82;
            4'd7: seg_code = 8'hF8;
            4'd8: seg_code = 8'h80;
            4'd9: seg_code = 8'h90;
            default: seg_code = 8'hFF;
        endcase
    end

    // Leading blank cycles of each slot hide ghosting while the digit enables swap
    assign blank = (count_reg < BLANK_END) || (state_reg == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_reg   <= 6'h3F;
            sseg_reg <= 8'hFF;
        end else if (blank) begin
            en_reg   <= 6'h3F;
            sseg_reg <= 8'hFF;
        end else begin
            en_reg   <= en_active;
            sseg_reg <= {~dp_sel, seg_code[6:0]};
        end
    end

    assign bus.gnt_a      = gnt_a_reg;
    assign bus.gnt_b      = gnt_b_reg;
    assign bus.frame_done = frame_done_reg;
    assign bus.sseg       = sseg_reg;
    assign bus.en         = en_reg;
endmodule

// File: tb/tb_sseg_scan_arbiter.sv
// Directed bench for sseg_scan_arbiter with CLK_DIV=4, BLANK=1, HOLD_FRAMES=2 (24-cycle frames).
// Time t counts rising edges since reset release; outputs are sampled 1 ns after each edge.
`timescale 1ns/1ps
module tb_sseg_scan_arbiter;
    logic clk;
    logic rst;
    int   t;
    int   vec_cnt;
    int   err_cnt;

    sseg_scan_arbiter_if bus();

    sseg_scan_arbiter #(
        .CLK_DIV    (4),
        .BLANK      (1),
        .HOLD_FRAMES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end else begin
            $display("ok   %s t=%0d val=%h", tag, t, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic run_to(input int k);
        while (t < k) tick();
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        t   = 0;
    endtask

    task automatic chk_disp(input string tag, input logic [7:0] en_exp, input logic [7:0] sseg_exp);
        chk({tag, ".en"}, 8'(bus.en), en_exp);
        chk({tag, ".sseg"}, bus.sseg, sseg_exp);
    endtask

    initial begin
        vec_cnt    = 0;
        err_cnt    = 0;
        t          = 0;
        rst        = 1'b1;
        bus.req_a  = 1'b0;
        bus.req_b  = 1'b0;
        bus.data_a = 24'h0;
        bus.data_b = 24'h0;
        bus.dp_a   = 6'h0;
        bus.dp_b   = 6'h0;

        // Reset state, then an idle display with frame_done every 24 edges
        #12;
        chk("rst.gnt_a", 8'(bus.gnt_a), 8'h00);
        chk("rst.gnt_b", 8'(bus.gnt_b), 8'h00);
        chk("rst.frame_done", 8'(bus.frame_done), 8'h00);
        chk_disp("rst", 8'h3F, 8'hFF);
        release_reset();
        for (int k = 1; k <= 48; k++) begin
            tick();
            chk_disp("idle", 8'h3F, 8'hFF);
            chk("idle.frame_done", 8'(bus.frame_done), ((k % 24) == 0) ? 8'h01 : 8'h00);
            chk("idle.gnt_a", 8'(bus.gnt_a), 8'h00);
        end

        // Single requester A, then A drops its request
        rst = 1'b1;
        bus.req_a  = 1'b1;
        bus.data_a = 24'h543210;
        bus.dp_a   = 6'h00;
        release_reset();
        run_to(23);
        chk("a.gnt_a_pre", 8'(bus.gnt_a), 8'h00);
        run_to(24);
        chk("a.gnt_a", 8'(bus.gnt_a), 8'h01);
        chk("a.gnt_b", 8'(bus.gnt_b), 8'h00);
        chk("a.frame_done", 8'(bus.frame_done), 8'h01);
        run_to(25); chk_disp("a.s0c0", 8'h3F, 8'hFF);
        chk("a.frame_done_end", 8'(bus.frame_done), 8'h00);
        run_to(26); chk_disp("a.s0c1", 8'h3E, 8'hC0);
        run_to(28); chk_disp("a.s0c3", 8'h3E, 8'hC0);
        run_to(29); chk_disp("a.s1c0", 8'h3F, 8'hFF);
        run_to(30); chk_disp("a.s1c1", 8'h3D, 8'hF9);
        run_to(37); chk_disp("a.s3c0", 8'h3F, 8'hFF);
        run_to(38); chk_disp("a.s3c1", 8'h37, 8'hB0);
        run_to(40); chk_disp("a.s3c3", 8'h37, 8'hB0);
        run_to(41); chk_disp("a.s4c0", 8'h3F, 8'hFF);
        bus.req_a = 1'b0;
        run_to(42); chk_disp("a.s4c1", 8'h2F, 8'h99);
        run_to(47); chk_disp("a.s5c2", 8'h1F, 8'h92);
        run_to(48);
        chk_disp("a.s5c3", 8'h1F, 8'h92);
        chk("drop.gnt_a", 8'(bus.gnt_a), 8'h00);
        chk("drop.gnt_b", 8'(bus.gnt_b), 8'h00);
        run_to(50); chk_disp("drop.s0c1", 8'h3F, 8'hFF);
        run_to(62); chk_disp("drop.s3c1", 8'h3F, 8'hFF);

        // Both requesting from reset: owners A, A, B, B, A
        rst = 1'b1;
        bus.req_a  = 1'b1;
        bus.req_b  = 1'b1;
        bus.data_a = 24'h888888;
        bus.data_b = 24'h999999;
        bus.dp_a   = 6'h00;
        bus.dp_b   = 6'h00;
        release_reset();
        run_to(24);
        chk("rr1.gnt_a", 8'(bus.gnt_a), 8'h01);
        chk("rr1.gnt_b", 8'(bus.gnt_b), 8'h00);
        run_to(26); chk_disp("rr1.s0c1", 8'h3E, 8'h80);
        run_to(48);
        chk("rr2.gnt_a", 8'(bus.gnt_a), 8'h01);
        chk("rr2.gnt_b", 8'(bus.gnt_b), 8'h00);
        run_to(71);
        chk("rr2.gnt_a_late", 8'(bus.gnt_a), 8'h01);
        run_to(72);
        chk("rr3.gnt_a", 8'(bus.gnt_a), 8'h00);
        chk("rr3.gnt_b", 8'(bus.gnt_b), 8'h01);
        run_to(74); chk_disp("rr3.s0c1", 8'h3E, 8'h90);
        run_to(96);
        chk("rr4.gnt_b", 8'(bus.gnt_b), 8'h01);
        run_to(120);
        chk("rr5.gnt_a", 8'(bus.gnt_a), 8'h01);
        chk("rr5.gnt_b", 8'(bus.gnt_b), 8'h00);

        // Mid-frame data change is deferred to the next boundary
        rst = 1'b1;
        bus.req_a  = 1'b1;
        bus.req_b  = 1'b0;
        bus.data_a = 24'h111111;
        bus.dp_a   = 6'h00;
        release_reset();
        run_to(27);
        bus.data_a = 24'h0A0200;
        bus.dp_a   = 6'b000100;
        run_to(34); chk_disp("tear.old_s2", 8'h3B, 8'hF9);
        run_to(50); chk_disp("tear.new_s0", 8'h3E, 8'hC0);
        run_to(58); chk_disp("tear.dp_s2", 8'h3B, 8'h24);
        run_to(60); chk("tear.gnt_a", 8'(bus.gnt_a), 8'h01);

        // Asynchronous reset mid-slot takes effect before any clock edge
        #3;
        rst = 1'b1;
        #1;
        chk("arst.gnt_a", 8'(bus.gnt_a), 8'h00);
        chk("arst.frame_done", 8'(bus.frame_done), 8'h00);
        chk_disp("arst", 8'h3F, 8'hFF);
        release_reset();
        run_to(23);
        chk("arst.gnt_a_pre", 8'(bus.gnt_a), 8'h00);
        chk("arst.frame_done_pre", 8'(bus.frame_done), 8'h00);
        run_to(24);
        chk("arst.gnt_a_first", 8'(bus.gnt_a), 8'h01);
        chk("arst.frame_done_first", 8'(bus.frame_done), 8'h01);
        run_to(42); chk_disp("arst.code_a", 8'h2F, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/sseg_scan_arbiter.md
SSEG_SCAN_ARBITER -- requirements
Module: sseg_scan_arbiter

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 25000: clk cycles per digit slot (minimum 4).
REQ-002 The block SHALL have parameter BLANK, default 2: leading clk cycles of each slot with all digits off (less than CLK_DIV).
REQ-003 The block SHALL have parameter HOLD_FRAMES, default 8: minimum frames an owner keeps the display when the other side is requesting (minimum 1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all state SHALL be clocked on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have ports req_a and req_b, input, 1 bit each: requests for display ownership from requesters A and B.
REQ-007 The block SHALL have ports data_a and data_b, input, 24 bits each: six 4-bit digit codes, with digit i in bits [4i+3:4i].
REQ-008 The block SHALL have ports dp_a and dp_b, input, 6 bits each: decimal point request for digit i, 1 = lit.
REQ-009 The block SHALL have ports gnt_a and gnt_b, output, 1 bit each, registered: current owner indication; the two SHALL never both be 1.
REQ-010 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse per completed 6-digit frame.
REQ-011 The block SHALL have port sseg, output, 8 bits, active-low, registered: bits 6:0 are segments g..a and bit 7 is the decimal point.
REQ-012 The block SHALL have port en, output, 6 bits, active-low, registered: digit enables, with bit i driving digit i.

Function
REQ-013 Prescaler: counts 0 to CLK_DIV-1 and then wraps to 0; slot_tick = (count == CLK_DIV-1).
REQ-014 Digit index: 0 to 5, advances on slot_tick and wraps 5 -> 0; frame length is 6*CLK_DIV cycles.
REQ-015 Frame boundary: the slot_tick edge with index 5; frame_done SHALL be 1 for exactly the cycle following that edge.
REQ-016 Arbiter states: IDLE, OWN_A, OWN_B; state, gnt_a, gnt_b, the shadow registers and the hold counter SHALL change only at the frame-boundary edge.
REQ-017 From IDLE, the arbiter SHALL move to the single requester if only one is requesting.
REQ-018 From IDLE with both requesting, the arbiter SHALL grant the side not granted last (round-robin pointer), then update the pointer.
REQ-019 From IDLE with no requests, the arbiter SHALL stay in IDLE.
REQ-020 From OWN_x with req_x low, the arbiter SHALL go to OWN_other if the other side is requesting, else to IDLE.
REQ-021 From OWN_x with req_x high, the other side requesting and hold_cnt >= HOLD_FRAMES-1, the arbiter SHALL go to OWN_other.
REQ-022 From OWN_x in all other cases, the arbiter SHALL stay in OWN_x and increment hold_cnt, saturating.
REQ-023 On every grant change, hold_cnt SHALL reset to 0.
REQ-024 gnt_a SHALL equal (state == OWN_A) and gnt_b SHALL equal (state == OWN_B).
REQ-025 Requests are level-sampled only at the boundary, so a request pulse shorter than a frame MAY be missed.
REQ-026 At each boundary, the new owner's data and dp SHALL be copied into 24-bit and 6-bit shadow registers; the display SHALL use only the shadow registers, so no tearing occurs within a frame.
REQ-027 Decode codes 0-9 -> 8'hC0, F9, A4, B0, 99, 92, 82, F8, 80, 90; codes 10-15 -> 8'hFF (blank).
REQ-028 sseg[7] SHALL be the inverse of shadow dp[idx].
REQ-029 Outputs SHALL lag the (count, idx) state by exactly one clk.
REQ-030 When count < BLANK, or the state is IDLE, the block SHALL drive en = 6'h3F and sseg = 8'hFF.
REQ-031 Otherwise, en SHALL be all ones except bit idx = 0, and sseg SHALL be the decode of the shadow digit at idx.
REQ-032 Grant latency: a request made while IDLE SHALL be granted at the next boundary, at most 6*CLK_DIV cycles later.

Reset
REQ-033 Asserting rst SHALL immediately clear prescaler, idx, hold_cnt and shadow registers to 0.
REQ-034 Asserting rst SHALL immediately set state = IDLE and the round-robin pointer to "B last" (so A wins the first tie).
REQ-035 Asserting rst SHALL immediately drive gnt_a = gnt_b = 0, frame_done = 0, en = 6'h3F and sseg = 8'hFF.
REQ-036 Reset asserted mid-frame SHALL abandon that frame; the first boundary after release SHALL occur 6*CLK_DIV cycles after release.

Verification (CLK_DIV=4, BLANK=1, HOLD_FRAMES=2)
REQ-037 Bench: reset, no requests -> en = 3F and sseg = FF throughout; frame_done pulses every 24 cycles.
REQ-038 Bench: req_a = 1, data_a = 24'h543210, dp_a = 0 -> gnt_a after the first boundary; then in slot 0 en = 3E, sseg = C0, and in slot 3 en = 37, sseg = B0, with en = 3F for the first output cycle of each slot.
REQ-039 Bench: both requesting from reset -> owner sequence A, A, B, B, A per frame.
REQ-040 Bench: owner drops req with the other side idle -> IDLE at the next boundary, display blank.
REQ-041 Bench: data_a changed mid-frame -> old digits shown until the boundary; code 4'hA shows FF; dp_a[2] = 1 with code 2 shows sseg = 24 on digit 2.
REQ-042 Bench: rst pulsed mid-slot with gnt_a = 1 -> same-cycle gnt_a = 0, en = 3F, sseg = FF, before any clk edge.
